shift_register_sequenced: RTL
=============================

# shift_register_sequenced

Parametrised universal shift register for the multiplier datapath. It supports parallel load, single-step shifts on demand, and an autonomous sequencer that performs N consecutive shifts from one `start` pulse. Each shift can go left or right, and right shifts can be logical or arithmetic. The block feeds the serial operand bit to the add/accumulate stage, exposes the full register to the product path, and flags completion so the multiplier controller can hand off without counting shifts itself.

## Interface
- `WORD_LENGTH`, default 8: register width, ≥ 2.
- `COUNT_WIDTH`, default `$clog2(WORD_LENGTH+1)`: width of the `shift_count` input. Derived; do not override.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `data_in`  in  WORD_LENGTH  parallel load value.
- `load`  in  1  load `data_in` on this edge.
- `shift`  in  1  one manual shift step. Ignored while `busy`.
- `direction`  in  1  0 = right (toward LSB), 1 = left.
- `arith`  in  1  right shifts replicate the MSB instead of taking `serial_in`. No effect on left shifts.
- `serial_in`  in  1  fill bit for the vacated end.
- `start`  in  1  begin an automatic sequence of `shift_count` shifts.
- `shift_count`  in  COUNT_WIDTH  number of steps, sampled with `start`.
- `data_out`  out  1  serial output: `reg[0]` when the effective direction is right, `reg[WORD_LENGTH-1]` when it is left.
- `parallel_out`  out  WORD_LENGTH  current register contents.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- Right step: `reg <= {fill, reg[W-1:1]}`, where `fill = arith ? reg[W-1] : serial_in`.
- Left step: `reg <= {reg[W-2:0], serial_in}`.
- `serial_in` is sampled live on every shift edge, including during a sequence.
- Priority each edge: `load` > `start` > `shift`.
- FSM states are `IDLE` and `RUN`.
- IDLE behaviour:
  - `load`: `reg <= data_in`; nothing else happens.
  - `start` with clamped count ≠ 0: latch `direction` and `arith`, set `remaining <= count`, go to `RUN`. No shift on this edge.
  - `start` with count = 0: no shift, stay in `IDLE`, assert `done` for the next cycle.
  - `shift`: one step using the live `direction` and `arith`.
- RUN behaviour:
  - Each edge: one step using the latched mode, then `remaining--`.
  - When `remaining == 1`, take the last step, go to `IDLE`, and assert `done` for the next cycle.
  - `load` during RUN: `reg <= data_in`, abort to `IDLE`. No final step and no `done`.
  - `start` and `shift` are ignored during RUN.
- `shift_count > WORD_LENGTH` is clamped to `WORD_LENGTH`.
- `data_out` effective direction: the latched direction while `busy`, otherwise the live `direction`. It is combinational from the register and that direction bit.
- `done` and `busy` are never high together.

## Timing
- Reset values: `reg = 0`, state `IDLE`, `remaining = 0`, `busy = 0`, `done = 0`, `parallel_out = 0`. `data_out` is therefore 0.
- Reset asserted mid-sequence aborts the sequence with no `done` pulse.
- Load and manual shift: visible on `parallel_out` one cycle after the sampling edge.
- Sequence started at edge k with count N:
  - steps occur at edges k+1 … k+N;
  - `busy` is high from after edge k until after edge k+N (N cycles);
  - `done` is high for the cycle following edge k+N;
  - total latency is N+1 cycles.
- A new `start` is accepted in the same cycle `done` is high.

## Structure
- Package `shift_register_pkg` holds:
  - the `state_t` enum (`IDLE`, `RUN`);
  - `DIR_RIGHT = 1'b0` and `DIR_LEFT = 1'b1`.
- One sub-module, `shift_step_counter`: it loads the clamped count, decrements, and flags the last step. The FSM and register live in the top module.

## Test plan
All cases use `WORD_LENGTH = 8`.
- Reset during an 8-step sequence at step 3 → `parallel_out = 0`, `busy = 0` immediately, no `done` pulse.
- Load `8'hB4`, then manual right shift with `serial_in = 1`, `arith = 0` → `8'hDA`, `data_out = 0`.
- Load `8'h96`, start with count 3, right, `arith = 1` → `8'hF2` after edge k+3; `busy` high for 3 cycles; `done` high for 1 cycle.
- Load `8'h81`, start with count 2, left, `serial_in = 0` → `8'h04`; `data_out` follows MSB.
- Start with count 0 → `done` the next cycle, `busy` never high, value unchanged. Start with count 12 and logical right fill 0 → clamped to 8 steps, `busy` for 8 cycles, result `8'h00`.
- Count 5 sequence with `load 8'h3C` on the second RUN cycle → `parallel_out = 8'h3C`, `busy` drops, no `done`. A concurrent `shift` pulse has no effect.

Source files
------------

// File: rtl/shift_register_sequenced_pkg.sv
// Shared types and constants for the sequenced universal shift register.
package shift_register_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_register_sequenced_step_counter.sv
// Step counter for the automatic shift sequence: loads the clamped step
// count, counts down one per shift, and flags the final step.
module shift_step_counter
  import shift_register_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   step,
  input  logic                   clear,
  output logic                   count_zero,
  output logic                   last_step
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT  = COUNT_WIDTH'(WORD_LENGTH);
  localparam logic [COUNT_WIDTH-1:0] ZERO_COUNT = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] clamped;
  logic [COUNT_WIDTH-1:0] remaining;

  // Requests longer than the register are clamped to one full word of shifts.
  always_comb begin
    clamped = count_in;
    if (count_in > MAX_COUNT) begin
      clamped = MAX_COUNT;
    end else begin
      clamped = count_in;
    end
  end

  assign count_zero = (clamped == ZERO_COUNT);
  assign last_step  = (remaining == ONE_COUNT);

  // Remaining-step register: clear on abort, load on start, count down per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= ZERO_COUNT;
    end else if (clear) begin
      remaining <= ZERO_COUNT;
    end else if (load) begin
      remaining <= clamped;
    end else if (step && (remaining != ZERO_COUNT)) begin
      remaining <= remaining - ONE_COUNT;
    end else begin
      remaining <= remaining;
    end
  end

endmodule

// File: rtl/shift_register_sequenced.sv
// Universal shift register with parallel load, manual single steps and an
// automatic N-step sequencer that pulses done on completion.
module shift_register_sequenced
  import shift_register_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   load,
  input  logic                   shift,
  input  logic                   direction,
  input  logic                   arith,
  input  logic                   serial_in,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] shift_count,
  output logic                   data_out,
  output logic [WORD_LENGTH-1:0] parallel_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [WORD_LENGTH-1:0] ZERO_WORD = {WORD_LENGTH{1'b0}};

  state_t                 state;
  logic [WORD_LENGTH-1:0] shift_reg;
  logic                   run_dir;
  logic                   run_arith;
  logic                   cnt_load;
  logic                   cnt_step;
  logic                   cnt_clear;
  logic                   count_zero;
  logic                   last_step;
  logic                   eff_dir;

  // One shift step: left takes serial_in at the LSB; right fills the MSB with
  // either serial_in or a copy of the sign bit.
  function automatic logic [WORD_LENGTH-1:0] step_value(
    input logic [WORD_LENGTH-1:0] value,
    input logic                   dir,
    input logic                   ar,
    input logic                   fill_in
  );
    logic fill;
    fill = fill_in;
    if (dir == DIR_LEFT) begin
      step_value = {value[WORD_LENGTH-2:0], fill_in};
    end else begin
      fill       = ar ? value[WORD_LENGTH-1] : fill_in;
      step_value = {fill, value[WORD_LENGTH-1:1]};
    end
  endfunction

  shift_step_counter #(
    .WORD_LENGTH(WORD_LENGTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .count_in  (shift_count),
    .step      (cnt_step),
    .clear     (cnt_clear),
    .count_zero(count_zero),
    .last_step (last_step)
  );

  // Counter control mirrors the FSM priorities: load beats start in IDLE,
  // and a load during RUN aborts the sequence.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    cnt_clear = 1'b0;
    case (state)
      IDLE: begin
        if (!load && start) begin
          cnt_load = 1'b1;
        end else begin
          cnt_load = 1'b0;
        end
      end
      RUN: begin
        if (load) begin
          cnt_clear = 1'b1;
        end else begin
          cnt_step = 1'b1;
        end
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Sequencer FSM plus the shift register itself, with registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= ZERO_WORD;
      run_dir   <= DIR_RIGHT;
      run_arith <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= data_in;
          end else if (start) begin
            if (count_zero) begin
              done <= 1'b1;
            end else begin
              run_dir   <= direction;
              run_arith <= arith;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end else if (shift) begin
            shift_reg <= step_value(shift_reg, direction, arith, serial_in);
          end else begin
            shift_reg <= shift_reg;
          end
        end
        RUN: begin
          if (load) begin
            shift_reg <= data_in;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            shift_reg <= step_value(shift_reg, run_dir, run_arith, serial_in);
            if (last_step) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign eff_dir      = busy ? run_dir : direction;
  assign data_out     = (eff_dir == DIR_LEFT) ? shift_reg[WORD_LENGTH-1] : shift_reg[0];
  assign parallel_out = shift_reg;

endmodule
